// File: rtl/oc2_mem_pkg.sv
// oc2_mem_pkg: access size, FSM state and fault bit encodings for the memory stage
package oc2_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  localparam int FLT_MISALIGN = 0;
  localparam int FLT_TIMEOUT  = 1;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian store lane steering, load extract/extend and alignment check
module mem_lane_align
  import oc2_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        signext,
  input  logic [31:0] regb,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        aligned
);
  logic is_b, is_h;
  logic [31:0] sh;
  assign is_b = size == SZ_BYTE;
  assign is_h = size == SZ_HALF;
  assign sh = rdata >> {addr_lo, 3'b000};
  // reserved size falls through every ternary to word behaviour
  assign aligned = is_b | (is_h ? ~addr_lo[0] : addr_lo == 2'b00);
  assign be = is_b ? 4'b0001 << addr_lo : is_h ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
  assign wdata = is_b ? {4{regb[7:0]}} : is_h ? {2{regb[15:0]}} : regb;
  assign ldata = is_b ? {{24{signext & sh[7]}}, sh[7:0]} :
                 is_h ? {{16{signext & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: pipeline memory stage with req/ack handshake, stall, misalign and timeout faults
module mem_stage_hs
  import oc2_mem_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_signext,
  input  logic [31:0]       ex_mem_regb,
  input  logic              ex_mem_selwsource,
  input  logic [REG_W-1:0]  ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [31:0]       ex_mem_wbvalue,
  output logic              mem_mc_req,
  output logic              mem_mc_we,
  output logic [3:0]        mem_mc_be,
  output logic [ADDR_W-1:0] mem_mc_addr,
  output logic [31:0]       mem_mc_wdata,
  input  logic [31:0]       mem_mc_rdata,
  input  logic              mem_mc_ack,
  output logic              mem_stall,
  output logic [1:0]        mem_fault,
  output logic [REG_W-1:0]  mem_wb_regdest,
  output logic              mem_wb_writereg,
  output logic [31:0]       mem_wb_wbvalue
);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TMAX = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] CMAX = CW'(TMAX);
  state_e state;
  logic [CW-1:0] cnt;
  logic access, aligned, misalign, abort, bubble;
  logic [31:0] ldata;
  mem_lane_align u_align (
    .size    (ex_mem_size),
    .addr_lo (ex_mem_wbvalue[1:0]),
    .signext (ex_mem_signext),
    .regb    (ex_mem_regb),
    .rdata   (mem_mc_rdata),
    .be      (mem_mc_be),
    .wdata   (mem_mc_wdata),
    .ldata   (ldata),
    .aligned (aligned)
  );
  assign access = ex_mem_readmem | ex_mem_writemem;
  assign misalign = access & ~aligned;
  assign mem_mc_req = reset & access & aligned;
  assign mem_mc_we = ex_mem_writemem & ~ex_mem_readmem;
  assign mem_mc_addr = ex_mem_wbvalue[ADDR_W-1:0];
  assign abort = (TIMEOUT_CYC != 0) && state == ST_WAIT && !mem_mc_ack && cnt == CMAX;
  assign mem_stall = mem_mc_req & ~mem_mc_ack & ~abort;
  // aborted and misaligned accesses advance the pipeline but retire as bubbles
  assign bubble = mem_stall | abort | misalign;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      mem_fault       <= '0;
      mem_wb_regdest  <= '0;
      mem_wb_writereg <= 1'b0;
      mem_wb_wbvalue  <= '0;
    end else begin
      state                  <= mem_stall ? ST_WAIT : ST_IDLE;
      cnt                    <= (state == ST_WAIT && mem_stall) ? cnt + 1'b1 : '0;
      mem_fault[FLT_MISALIGN] <= misalign;
      mem_fault[FLT_TIMEOUT]  <= abort;
      mem_wb_regdest         <= bubble ? '0 : ex_mem_regdest;
      mem_wb_writereg        <= bubble ? 1'b0 : ex_mem_writereg;
      mem_wb_wbvalue         <= bubble ? '0 : (ex_mem_selwsource & ex_mem_readmem) ? ldata : ex_mem_wbvalue;
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed self-checking bench for mem_stage_hs with TIMEOUT_CYC=4
module tb_mem_stage_hs;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        readmem, writemem, signext, selwsource, writereg, ack;
  logic [1:0]  size;
  logic [31:0] regb, wbvalue, rdata;
  logic [4:0]  regdest;
  logic        req, we, stall, wb_writereg;
  logic [3:0]  be;
  logic [17:0] addr;
  logic [31:0] wdata, wb_wbvalue;
  logic [1:0]  fault;
  logic [4:0]  wb_regdest;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_stage_hs #(.ADDR_W(18), .REG_W(5), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset),
    .ex_mem_readmem(readmem), .ex_mem_writemem(writemem), .ex_mem_size(size),
    .ex_mem_signext(signext), .ex_mem_regb(regb), .ex_mem_selwsource(selwsource),
    .ex_mem_regdest(regdest), .ex_mem_writereg(writereg), .ex_mem_wbvalue(wbvalue),
    .mem_mc_req(req), .mem_mc_we(we), .mem_mc_be(be), .mem_mc_addr(addr),
    .mem_mc_wdata(wdata), .mem_mc_rdata(rdata), .mem_mc_ack(ack),
    .mem_stall(stall), .mem_fault(fault),
    .mem_wb_regdest(wb_regdest), .mem_wb_writereg(wb_writereg), .mem_wb_wbvalue(wb_wbvalue)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    readmem = 0; writemem = 0; size = 2'b10; signext = 0; regb = 0;
    selwsource = 0; regdest = 0; writereg = 0; wbvalue = 0; rdata = 0; ack = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_wr"}, {31'd0, wb_writereg}, 0);
    chk({tag, "_rd"}, {27'd0, wb_regdest}, 0);
    chk({tag, "_val"}, wb_wbvalue, 0);
  endtask

  initial begin
    clr();
    #2;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_fault", {30'd0, fault}, 0);
    chk_bubble("rst_wb");
    tick();
    reset = 1;
    tick();
    // SW zero-wait
    writemem = 1; size = 2'b10; regb = 32'hDEADBEEF; wbvalue = 32'h10; regdest = 3; ack = 1;
    #1;
    chk("sw_req", {31'd0, req}, 1);
    chk("sw_we", {31'd0, we}, 1);
    chk("sw_be", {28'd0, be}, 32'hF);
    chk("sw_wdata", wdata, 32'hDEADBEEF);
    chk("sw_addr", {14'd0, addr}, 32'h10);
    chk("sw_stall", {31'd0, stall}, 0);
    tick();
    chk("sw_wb_rd", {27'd0, wb_regdest}, 3);
    chk("sw_wb_val", wb_wbvalue, 32'h10);
    chk("sw_fault", {30'd0, fault}, 0);
    // non-memory op
    clr(); writereg = 1; regdest = 2; wbvalue = 32'h1234;
    #1;
    chk("alu_req", {31'd0, req}, 0);
    chk("alu_stall", {31'd0, stall}, 0);
    tick();
    chk("alu_wb_wr", {31'd0, wb_writereg}, 1);
    chk("alu_wb_rd", {27'd0, wb_regdest}, 2);
    chk("alu_wb_val", wb_wbvalue, 32'h1234);
    // LB signext, 3 wait cycles
    clr(); readmem = 1; size = 2'b00; signext = 1; wbvalue = 32'h3; selwsource = 1;
    regdest = 5; writereg = 1; rdata = 32'h80FFFF7F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", {31'd0, stall}, 1);
      chk("lb_be", {28'd0, be}, 32'h8);
      chk("lb_we", {31'd0, we}, 0);
      tick();
      chk_bubble("lb_bub");
    end
    ack = 1;
    #1;
    chk("lb_ack_stall", {31'd0, stall}, 0);
    tick();
    chk("lb_wb_val", wb_wbvalue, 32'hFFFFFF80);
    chk("lb_wb_rd", {27'd0, wb_regdest}, 5);
    chk("lb_wb_wr", {31'd0, wb_writereg}, 1);
    // SH lanes
    clr(); writemem = 1; size = 2'b01; wbvalue = 32'h2; regb = 32'h00001234; ack = 1;
    #1;
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", wdata, 32'h12341234);
    tick();
    // LH misaligned
    clr(); readmem = 1; size = 2'b01; wbvalue = 32'h1; regdest = 7; writereg = 1; selwsource = 1;
    #1;
    chk("lh_mis_req", {31'd0, req}, 0);
    chk("lh_mis_stall", {31'd0, stall}, 0);
    tick();
    chk("lh_mis_fault", {30'd0, fault}, 32'h1);
    chk_bubble("lh_mis_bub");
    clr();
    tick();
    chk("lh_mis_pulse", {30'd0, fault}, 0);
    // LW timeout
    clr(); readmem = 1; size = 2'b10; wbvalue = 32'h20; regdest = 9; writereg = 1; selwsource = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", {31'd0, stall}, 1);
      tick();
    end
    #1;
    chk("to_abort_stall", {31'd0, stall}, 0);
    chk("to_abort_req", {31'd0, req}, 1);
    tick();
    chk("to_fault", {30'd0, fault}, 32'h2);
    chk("to_wb_wr", {31'd0, wb_writereg}, 0);
    clr();
    #1;
    chk("to_req_drop", {31'd0, req}, 0);
    tick();
    chk("to_pulse", {30'd0, fault}, 0);
    // read wins, then reset mid-WAIT
    clr(); readmem = 1; writemem = 1; size = 2'b10; wbvalue = 32'h40; regdest = 4; writereg = 1;
    #1;
    chk("rw_we", {31'd0, we}, 0);
    chk("rw_req", {31'd0, req}, 1);
    tick();
    tick();
    reset = 0;
    #1;
    chk("mid_rst_req", {31'd0, req}, 0);
    chk("mid_rst_stall", {31'd0, stall}, 0);
    chk("mid_rst_fault", {30'd0, fault}, 0);
    chk_bubble("mid_rst_wb");
    tick();
    reset = 1;
    writemem = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_stall", {31'd0, stall}, 1);
      tick();
    end
    #1;
    chk("post_rst_abort", {31'd0, stall}, 0);
    tick();
    chk("post_rst_fault", {30'd0, fault}, 32'h2);
    clr();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
